perf_counter_ctrl: RTL

Programmable controller for a bank of `NUM_COUNTERS` event counters in the CPU performance-monitoring path.
- Routes one of `NUM_EVENTS` single-cycle event strobes to each counter.
- Gates all counting with a RUN/IDLE/DONE window scheduler.
- Exposes configuration, counts and sticky overflow status through a small word-addressed request/response port.
- Raises an interrupt when a window finishes or an enabled counter wraps.

---
 rtl/perf_counter_ctrl.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl -- performance-monitor counter bank with a window scheduler.
//
// A small bank of event counters. Each counter picks one event strobe. Counting
// only happens while the scheduler is in RUN. Software drives the block through a
// word-addressed request/response port. The block raises a level interrupt when a
// counting window completes or when an enabled counter wraps.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   events       single-cycle event strobes, one bit per event
//   req/we/addr  request handshake (accepted on req && ready), write enable,
//   wdata        word address and write data
//   ready        request port can accept a request
//   resp_valid   one-cycle response strobe; rdata valid alongside it
//   rdata        read data (0 for writes)
//   irq          registered level interrupt

// One counter lane: the counter value plus its sticky overflow bit.
module perf_counter_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,      // selected event seen while running
    input  logic             clr_i,      // bank-wide CLEAR
    input  logic             ld_i,       // software write to this COUNT
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic             ovf_clr_i,  // W1C of this OVF bit
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             wrap;

    // CLEAR beats a load, and a load beats an increment. Only a real
    // increment from all-ones can wrap.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_data_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
            wrap  = &cnt_q;
        end
    end

    // A fresh wrap beats a same-cycle W1C, so the overflow is never lost.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_i)          ovf_d = 1'b0;
        else if (wrap)      ovf_d = 1'b1;
        else if (ovf_clr_i) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

module perf_counter_ctrl #(
    parameter int NUM_COUNTERS = 4,
    parameter int NUM_EVENTS   = 8,
    parameter int WIDTH        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  req,
    input  logic                  we,
    input  logic [3:0]            addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  ready,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      rdata,
    output logic                  irq
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t st_q, st_d;

    logic [4*NUM_COUNTERS-1:0]          evsel_q;
    logic [WIDTH-1:0]                   window_q;
    logic [WIDTH-1:0]                   elapsed_q, elapsed_d;
    logic [NUM_COUNTERS-1:0]            ovf_ie_q;
    logic                               done_flag_q, done_flag_d;
    logic                               irq_q;
    logic                               resp_valid_q;
    logic [WIDTH-1:0]                   rdata_q;

    logic [NUM_COUNTERS-1:0][WIDTH-1:0] cnt;
    logic [NUM_COUNTERS-1:0]            ovf;
    logic [7:0][WIDTH-1:0]              cnt_pad;
    logic [15:0]                        ev_pad;
    logic [WIDTH-1:0]                   rd_word;

    logic acc, wr, wr_ctrl, wr_status;
    logic start, stop, clear;
    logic run, window_hit, done_set;
    logic unused_wdata;

    // Request decode. A write takes effect at the accept edge.
    assign acc       = req && ready;
    assign wr        = acc && we;
    assign wr_ctrl   = wr && (addr == 4'h0);
    assign wr_status = wr && (addr == 4'h1);
    assign start     = wr_ctrl && wdata[0];
    assign stop      = wr_ctrl && wdata[1];
    assign clear     = wr_ctrl && wdata[2];

    // The last RUN cycle of a nonzero window is the one where ELAPSED
    // reaches WINDOW-1. ELAPSED steps to WINDOW on that same edge.
    assign window_hit = (window_q != '0) &&
                        (elapsed_q == window_q - {{(WIDTH-1){1'b0}}, 1'b1});

    // Scheduler: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= ST_IDLE;
        else     st_q <= st_d;
    end

    // Scheduler: next state. STOP always wins over START. A START in RUN
    // restarts the window instead of letting it complete.
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE: if (start && !stop) st_d = ST_RUN;
            ST_RUN: begin
                if (stop)            st_d = ST_IDLE;
                else if (start)      st_d = ST_RUN;
                else if (window_hit) st_d = ST_DONE;
            end
            ST_DONE: begin
                if (stop)       st_d = ST_IDLE;
                else if (start) st_d = ST_RUN;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Scheduler: outputs
    always_comb begin
        run      = (st_q == ST_RUN);
        done_set = (st_q == ST_RUN) && (st_d == ST_DONE);
    end

    // Pad events to 16 bits. Any select at or above NUM_EVENTS then lands
    // on a constant 0 and never counts.
    always_comb begin
        ev_pad = '0;
        ev_pad[NUM_EVENTS-1:0] = events;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_lane
            logic [3:0] sel;
            assign sel = evsel_q[4*gi +: 4];

            perf_counter_lane #(.WIDTH(WIDTH)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .inc_i     (run && ev_pad[sel]),
                .clr_i     (clear),
                .ld_i      (wr && (addr == 4'(8 + gi))),
                .ld_data_i (wdata),
                .ovf_clr_i (wr_status && wdata[8 + gi]),
                .cnt_o     (cnt[gi]),
                .ovf_o     (ovf[gi])
            );
        end
    endgenerate

    // ELAPSED: cleared by CLEAR or an effective START. Otherwise it counts
    // every RUN cycle.
    always_comb begin
        elapsed_d = elapsed_q;
        if (clear || (start && !stop)) elapsed_d = '0;
        else if (run)                  elapsed_d = elapsed_q + 1'b1;
    end

    // DONE_FLAG: setting it beats a same-cycle W1C.
    always_comb begin
        done_flag_d = done_flag_q;
        if (done_set)                     done_flag_d = 1'b1;
        else if (wr_status && wdata[2])   done_flag_d = 1'b0;
    end

    // Read mux over pre-update register values. COUNT slots past
    // NUM_COUNTERS read as zero through the padded array.
    always_comb begin
        cnt_pad = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) cnt_pad[i] = cnt[i];
    end

    always_comb begin
        rd_word = '0;
        if (addr[3]) begin
            rd_word = cnt_pad[addr[2:0]];
        end else begin
            unique case (addr[2:0])
                3'h0: rd_word[8 +: NUM_COUNTERS] = ovf_ie_q;
                3'h1: begin
                    rd_word[1:0]              = st_q;
                    rd_word[2]                = done_flag_q;
                    rd_word[8 +: NUM_COUNTERS] = ovf;
                end
                3'h2: rd_word = window_q;
                3'h3: rd_word[4*NUM_COUNTERS-1:0] = evsel_q;
                3'h4: rd_word = elapsed_q;
                default: rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evsel_q      <= '0;
            window_q     <= '0;
            elapsed_q    <= '0;
            ovf_ie_q     <= '0;
            done_flag_q  <= 1'b0;
            irq_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (wr_ctrl)                   ovf_ie_q <= wdata[8 +: NUM_COUNTERS];
            if (wr && (addr == 4'h2))      window_q <= wdata;
            if (wr && (addr == 4'h3))      evsel_q  <= wdata[4*NUM_COUNTERS-1:0];
            elapsed_q    <= elapsed_d;
            done_flag_q  <= done_flag_d;
            irq_q        <= done_flag_q | (|(ovf & ovf_ie_q));
            resp_valid_q <= acc;
            rdata_q      <= (acc && !we) ? rd_word : '0;
        end
    end

    assign unused_wdata = ^wdata;

    // The port is busy during the response cycle. This caps throughput at
    // one request every two cycles.
    assign ready      = !resp_valid_q;
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign irq        = irq_q;
endmodule
